mem_port_arbiter: RTL and testbench

Two-master arbiter that shares the single RAM port (16-bit address, 8-bit data, `OE_M`/`WE_M` strobes) between the CPU datapath (master 0) and the debug/boot loader port (master 1). It replaces ad-hoc forcing of the memory bus with a req/gnt/done handshake. Transactions are sequenced through a three-state FSM. Fixed priority goes to the CPU, with a starvation guard and a loader lock for burst loads. Out-of-map addresses (bit 15 set) are rejected without touching RAM.

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between the CPU (m0) and the loader (m1) with a fixed-priority, starvation-guarded arbiter.
// Latency: req sampled in IDLE -> gnt/strobe next cycle -> done/rdata the cycle after (3 cycles per transaction).
// Backpressure: a master holds req until its done pulse; requests that arrive outside IDLE wait for the next IDLE.
module mem_port_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_addr,
  input  logic [7:0]  m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  input  logic        m1_lock,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_done,
  output logic        m1_done,
  output logic [7:0]  m0_rdata,
  output logic [7:0]  m1_rdata,
  output logic        m0_err,
  output logic        m1_err,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_oe,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t        state_q, state_d;
  logic          id_q, id_d;          // 0 = m0 owns the transaction, 1 = m1
  logic          we_q, we_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [WW-1:0] wait_q, wait_d;      // m0 grants taken while m1 was waiting
  logic [7:0]    m0_rdata_q, m0_rdata_d;
  logic [7:0]    m1_rdata_q, m1_rdata_d;
  logic          m0_err_q, m0_err_d;
  logic          m1_err_q, m1_err_d;
  logic          win1;

  // m1 wins on lock, on an exhausted wait budget, or when the CPU is not asking
  assign win1 = m1_req & (m1_lock | (wait_q == WW'(MAX_WAIT)) | ~m0_req);

  // Next-state, request latching and per-master result registers
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    wait_d     = wait_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_err_d   = m0_err_q;
    m1_err_d   = m1_err_q;
    case (state_q)
      IDLE: begin
        if (m0_req | m1_req) begin
          state_d = ISSUE;
          id_d    = win1;
          we_d    = win1 ? m1_we    : m0_we;
          addr_d  = win1 ? m1_addr  : m0_addr;
          wdata_d = win1 ? m1_wdata : m0_wdata;
          err_d   = win1 ? m1_addr[15] : m0_addr[15];
          if (win1) begin
            m1_err_d = 1'b0;
            wait_d   = '0;
          end else begin
            m0_err_d = 1'b0;
            if (m1_req && (wait_q != WW'(MAX_WAIT))) wait_d = wait_q + 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = DONE;
        if (id_q) begin
          m1_err_d = err_q;
          if (err_q)      m1_rdata_d = 8'h00;
          else if (!we_q) m1_rdata_d = mem_rdata;
        end else begin
          m0_err_d = err_q;
          if (err_q)      m0_rdata_d = 8'h00;
          else if (!we_q) m0_rdata_d = mem_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      wait_q     <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
    end
  end

  // Strobes are masked by reset so an ISSUE cut short by reset never writes RAM
  assign mem_oe    = (state_q == ISSUE) & ~we_q & ~err_q & ~reset;
  assign mem_we    = (state_q == ISSUE) &  we_q & ~err_q & ~reset;
  assign mem_addr  = (state_q == ISSUE) ? addr_q  : '0;
  assign mem_wdata = (state_q == ISSUE) ? wdata_q : '0;
  assign m0_gnt    = (state_q == ISSUE) & ~id_q;
  assign m1_gnt    = (state_q == ISSUE) &  id_q;
  assign m0_done   = (state_q == DONE)  & ~id_q;
  assign m1_done   = (state_q == DONE)  &  id_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_err    = m0_err_q;
  assign m1_err    = m1_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios followed by random traffic against a rule-level reference model.
// Latency: each transaction is checked cycle by cycle over its 3-cycle sequence.
// Backpressure: requests are driven only while the arbiter is idle and held through the transaction.
module tb_mem_port_arbiter;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [15:0] m0_addr, m1_addr;
  logic [7:0]  m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err;
  logic [7:0]  m0_rdata, m1_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_oe, mem_we, busy;

  bit [7:0] ram     [0:65535];
  bit [7:0] ref_mem [0:65535];
  logic [7:0] exp_rd  [2];
  logic       exp_err [2];
  int ref_wait;
  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_done(m0_done), .m1_done(m1_done),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_err(m0_err), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_oe(mem_oe), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // External RAM: combinational read, write on the clock edge
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ref_wait   = 0;
    exp_rd[0]  = 8'h00;
    exp_rd[1]  = 8'h00;
    exp_err[0] = 1'b0;
    exp_err[1] = 1'b0;
  endtask

  // Drive one arbitration opportunity and check every cycle of the result
  task automatic txn(input bit r0, input bit r1, input bit lk, input bit w0, input bit w1,
                     input logic [15:0] a0, input logic [15:0] a1,
                     input logic [7:0] d0, input logic [7:0] d1, output int won);
    int win;
    bit ewe, eerr;
    logic [15:0] ea;
    logic [7:0] ed;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_lock = lk;
    won = -1;
    if (!r0 && !r1) begin
      @(posedge clk); #1;
      chk("idle_busy", {31'b0, busy}, 0);
    end else begin
      if (r1 && lk)                    win = 1;
      else if (r1 && ref_wait == MAX_WAIT) win = 1;
      else if (r0)                     win = 0;
      else                             win = 1;
      if (win == 1) ref_wait = 0;
      else if (r1 && ref_wait < MAX_WAIT) ref_wait++;
      ewe  = win ? w1 : w0;
      ea   = win ? a1 : a0;
      ed   = win ? d1 : d0;
      eerr = ea[15];
      exp_err[win] = eerr;
      if (eerr)      exp_rd[win] = 8'h00;
      else if (!ewe) exp_rd[win] = ref_mem[ea];
      else           ref_mem[ea] = ed;

      @(posedge clk); #1;
      won = m1_gnt ? 1 : (m0_gnt ? 0 : -1);
      chk("issue_gnt0", {31'b0, m0_gnt}, {31'b0, win == 0});
      chk("issue_gnt1", {31'b0, m1_gnt}, {31'b0, win == 1});
      chk("issue_busy", {31'b0, busy}, 1);
      chk("issue_oe", {31'b0, mem_oe}, {31'b0, !ewe && !eerr});
      chk("issue_we", {31'b0, mem_we}, {31'b0, ewe && !eerr});
      chk("issue_addr", {16'b0, mem_addr}, {16'b0, ea});
      if (ewe && !eerr) chk("issue_wdata", {24'b0, mem_wdata}, {24'b0, ed});

      @(posedge clk); #1;
      chk("done0", {31'b0, m0_done}, {31'b0, win == 0});
      chk("done1", {31'b0, m1_done}, {31'b0, win == 1});
      chk("done_busy", {31'b0, busy}, 1);
      chk("done_strobes", {30'b0, mem_oe, mem_we}, 0);
      chk("rdata0", {24'b0, m0_rdata}, {24'b0, exp_rd[0]});
      chk("rdata1", {24'b0, m1_rdata}, {24'b0, exp_rd[1]});
      chk("err0", {31'b0, m0_err}, {31'b0, exp_err[0]});
      chk("err1", {31'b0, m1_err}, {31'b0, exp_err[1]});

      @(posedge clk); #1;
      chk("idle_after", {29'b0, busy, m0_done, m1_done}, 0);
    end
  endtask

  initial begin
    int won;
    int order [10];
    order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 64; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[16'h0003] = 8'hA5; ref_mem[16'h0003] = 8'hA5;
    ram[16'h0020] = 8'h3C; ref_mem[16'h0020] = 8'h3C;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_lock = 0;
    model_reset();

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {24'b0, m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, mem_oe, mem_we}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_bus", {8'b0, mem_addr, mem_wdata}, 0);
    chk("rst_rdata", {16'b0, m0_rdata, m1_rdata}, 0);
    reset = 1'b0;

    // m0 read of a preloaded location
    txn(1, 0, 0, 0, 0, 16'h0003, 16'h0, 8'h0, 8'h0, won);
    chk("m0_read_value", {24'b0, m0_rdata}, 32'hA5);

    // m1 write then read back
    txn(0, 1, 0, 0, 1, 16'h0, 16'h0010, 8'h0, 8'h25, won);
    txn(0, 1, 0, 0, 0, 16'h0, 16'h0010, 8'h0, 8'h00, won);
    chk("m1_readback", {24'b0, m1_rdata}, 32'h25);

    // Starvation guard with both masters requesting continuously
    for (int i = 0; i < 10; i++) begin
      txn(1, 1, 0, 0, 0, 16'(i), 16'(i + 32), 8'h0, 8'h0, won);
      chk("starve_order", 32'(won), 32'(order[i]));
    end

    // Loader lock overrides CPU priority, then releases it
    for (int i = 0; i < 3; i++) begin
      txn(1, 1, 1, 0, 1, 16'h0005, 16'(16'h0030 + i), 8'h0, 8'(8'h40 + i), won);
      chk("lock_m1", 32'(won), 1);
    end
    txn(1, 1, 0, 0, 0, 16'h0005, 16'h0031, 8'h0, 8'h0, won);
    chk("unlock_m0", 32'(won), 0);

    // Address errors: read returns 0 with err, write leaves RAM untouched
    txn(1, 0, 0, 0, 0, 16'h8000, 16'h0, 8'h0, 8'h0, won);
    chk("err_read_flag", {31'b0, m0_err}, 1);
    chk("err_read_data", {24'b0, m0_rdata}, 0);
    txn(0, 1, 0, 0, 1, 16'h0, 16'h8002, 8'h0, 8'hEE, won);
    chk("err_write_flag", {31'b0, m1_err}, 1);
    txn(0, 1, 0, 0, 0, 16'h0, 16'h0002, 8'h0, 8'h0, won);
    chk("err_write_ram", {24'b0, m1_rdata}, {24'b0, ref_mem[16'h0002]});
    chk("err_cleared", {31'b0, m1_err}, 0);

    // Reset during ISSUE aborts the write
    m0_req = 0; m1_req = 1; m1_we = 1; m1_addr = 16'h0020; m1_wdata = 8'h8F; m1_lock = 0;
    @(posedge clk); #1;
    chk("abort_gnt", {31'b0, m1_gnt}, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_outs", {24'b0, m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, mem_oe, mem_we}, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_bus", {8'b0, mem_addr, mem_wdata}, 0);
    chk("abort_rdata", {16'b0, m0_rdata, m1_rdata}, 0);
    reset = 1'b0;
    m1_req = 0;
    model_reset();
    txn(1, 0, 0, 0, 0, 16'h0020, 16'h0, 8'h0, 8'h0, won);
    chk("abort_ram_kept", {24'b0, m0_rdata}, 32'h3C);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      logic [15:0] ra0, ra1;
      ra0 = {($urandom_range(0, 7) == 0), 9'b0, 6'($urandom)};
      ra1 = {($urandom_range(0, 7) == 0), 9'b0, 6'($urandom)};
      txn(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
          ra0, ra1, 8'($urandom), 8'($urandom), won);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
